spi_accel_responder: RTL

SPI_ACCEL_RESPONDER -- requirements
Module: spi_accel_responder

---
 rtl/spi_accel_responder.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/spi_accel_responder.sv
// SPI mode-3 register responder for a 3-axis accelerometer core.
// Define ACCEL_MB_EN to enable multi-byte bursts with address auto-increment.
module spi_accel_responder (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    input  logic [9:0] x_sample,
    input  logic [9:0] y_sample,
    input  logic [9:0] z_sample,
    output logic [7:0] power_ctl,
    output logic [7:0] bw_rate,
    output logic [7:0] data_format,
    output logic       measure,
    output logic       wr_strobe,
    output logic [5:0] wr_addr
);
    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t      r_state, w_next;
    logic        r_sclk_s1, r_sclk_s2, r_sclk_d;
    logic        r_cs_s1, r_cs_s2, r_cs_d;
    logic        r_mosi_s1, r_mosi_s2;
    logic [1:0]  r_fill;
    logic        r_armed;
    logic [2:0]  r_cnt;
    logic [6:0]  r_shift_in;
    logic [7:0]  r_tx;
    logic [5:0]  r_addr;
    logic        r_rw, r_done, r_miso, r_wr_strobe;
    logic [5:0]  r_wr_addr;
    logic [7:0]  r_bw, r_pwr, r_fmt;
    logic [9:0]  r_x, r_y, r_z;
`ifdef ACCEL_MB_EN
    logic        r_mb;
`endif

    logic        w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;
    logic        w_rise, w_cmd_done, w_byte_done, w_wr_ok;
    logic [7:0]  w_rx_byte, w_rd_data;
    logic [5:0]  w_rd_addr;

    // A falling cs_n seen straight out of reset is only accepted once
    // the synchronizer has observed cs_n high after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            {r_sclk_s1, r_sclk_s2, r_sclk_d} <= 3'b111;
            {r_cs_s1, r_cs_s2, r_cs_d}       <= 3'b111;
            {r_mosi_s1, r_mosi_s2}           <= 2'b00;
            r_fill  <= 2'b00;
            r_armed <= 1'b0;
        end else begin
            {r_sclk_s1, r_sclk_s2, r_sclk_d} <= {sclk, r_sclk_s1, r_sclk_s2};
            {r_cs_s1, r_cs_s2, r_cs_d}       <= {cs_n, r_cs_s1, r_cs_s2};
            {r_mosi_s1, r_mosi_s2}           <= {mosi, r_mosi_s1};
            r_fill <= {r_fill[0], 1'b1};
            if (r_fill[1] && r_cs_s2)
                r_armed <= 1'b1;
        end
    end

    assign w_sclk_rise = r_sclk_s2 & ~r_sclk_d;
    assign w_sclk_fall = ~r_sclk_s2 & r_sclk_d;
    assign w_cs_fall   = r_armed & r_cs_d & ~r_cs_s2;
    assign w_cs_rise   = r_cs_s2 & ~r_cs_d;
    assign w_rise      = w_sclk_rise && (r_state != IDLE) && !w_cs_rise;
    assign w_cmd_done  = w_rise && (r_state == CMD) && (r_cnt == 3'd7);
    assign w_byte_done = w_rise && (r_state == DATA) && (r_cnt == 3'd7);
    assign w_rx_byte   = {r_shift_in, r_mosi_s2};
    assign w_wr_ok     = (r_addr == 6'h2C) || (r_addr == 6'h2D) || (r_addr == 6'h31);
    assign w_rd_addr   = (r_state == CMD) ? w_rx_byte[5:0] : r_addr + 6'd1;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_cs_fall)  w_next = CMD;
            CMD:     if (w_cmd_done) w_next = DATA;
            DATA:    w_next = DATA;
            default: w_next = IDLE;
        endcase
        if (w_cs_rise)
            w_next = IDLE;
    end

    always_comb begin
        w_rd_data = 8'h00;
        case (w_rd_addr)
            6'h00:   w_rd_data = 8'hE5;
            6'h2C:   w_rd_data = r_bw;
            6'h2D:   w_rd_data = r_pwr;
            6'h31:   w_rd_data = r_fmt;
            6'h32:   w_rd_data = r_x[7:0];
            6'h33:   w_rd_data = {{6{r_x[9]}}, r_x[9:8]};
            6'h34:   w_rd_data = r_y[7:0];
            6'h35:   w_rd_data = {{6{r_y[9]}}, r_y[9:8]};
            6'h36:   w_rd_data = r_z[7:0];
            6'h37:   w_rd_data = {{6{r_z[9]}}, r_z[9:8]};
            default: w_rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= 3'd0;
            r_shift_in  <= 7'd0;
            r_tx        <= 8'h00;
            r_addr      <= 6'd0;
            r_rw        <= 1'b0;
            r_done      <= 1'b0;
            r_miso      <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= 6'd0;
            r_bw        <= 8'h0A;
            r_pwr       <= 8'h00;
            r_fmt       <= 8'h00;
            r_x         <= 10'd0;
            r_y         <= 10'd0;
            r_z         <= 10'd0;
`ifdef ACCEL_MB_EN
            r_mb        <= 1'b0;
`endif
        end else begin
            r_wr_strobe <= 1'b0;
            if (w_cs_fall) begin
                r_cnt  <= 3'd0;
                r_tx   <= 8'h00;
                r_done <= 1'b0;
                r_x    <= x_sample;
                r_y    <= y_sample;
                r_z    <= z_sample;
            end else if (w_rise) begin
                r_cnt      <= r_cnt + 3'd1;
                r_shift_in <= w_rx_byte[6:0];
                if (w_cmd_done) begin
                    r_rw   <= w_rx_byte[7];
                    r_addr <= w_rx_byte[5:0];
                    r_done <= 1'b0;
                    r_tx   <= w_rx_byte[7] ? w_rd_data : 8'h00;
`ifdef ACCEL_MB_EN
                    r_mb   <= w_rx_byte[6];
`endif
                end
                if (w_byte_done) begin
                    if (!r_rw && !r_done && w_wr_ok) begin
                        case (r_addr)
                            6'h2C:   r_bw  <= w_rx_byte;
                            6'h2D:   r_pwr <= w_rx_byte;
                            default: r_fmt <= w_rx_byte;
                        endcase
                        r_wr_strobe <= 1'b1;
                        r_wr_addr   <= r_addr;
                    end
`ifdef ACCEL_MB_EN
                    if (r_mb && !r_done) begin
                        r_addr <= r_addr + 6'd1;
                        r_tx   <= r_rw ? w_rd_data : 8'h00;
                    end else begin
                        r_done <= 1'b1;
                        r_tx   <= 8'h00;
                    end
`else
                    r_done <= 1'b1;
                    r_tx   <= 8'h00;
`endif
                end
            end
            // miso only carries data in DATA, shifted on falling sclk
            if (r_state != DATA) begin
                r_miso <= 1'b0;
            end else if (w_sclk_fall) begin
                r_miso <= r_tx[7];
                r_tx   <= {r_tx[6:0], 1'b0};
            end
        end
    end

    assign miso        = r_miso;
    assign power_ctl   = r_pwr;
    assign bw_rate     = r_bw;
    assign data_format = r_fmt;
    assign measure     = r_pwr[3];
    assign wr_strobe   = r_wr_strobe;
    assign wr_addr     = r_wr_addr;
endmodule
